// File: rtl/e_mdu_pkg.sv
// Shared MDU op codes and op-class helpers for e_mdu and mdu_arith.
// MDU_MADD_EN adds the multiply-accumulate ops to the multi-cycle class.
package e_mdu_pkg;

  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;
  localparam logic [3:0] MDU_MADD  = 4'd9;
  localparam logic [3:0] MDU_MADDU = 4'd10;
  localparam logic [3:0] MDU_MSUB  = 4'd11;
  localparam logic [3:0] MDU_MSUBU = 4'd12;

  function automatic logic is_mul_op(input logic [3:0] op);
    logic r;
    r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MDU_MADD) || (op == MDU_MADDU) ||
             (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational MDU datapath: next {HI,LO} and write-enable from latched op/operands/base.
// Divide-by-zero drops the write-enable; MADD/MSUB variants exist only with MDU_MADD_EN.
module mdu_arith
  import e_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n,
  output logic             we
);

  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    prod_s;
  logic [W2-1:0]    prod_u;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] q_u;
  logic [WIDTH-1:0] r_u;
  logic             div_ovf;
  logic             b_zero;

  always_comb begin
    // Low 2W bits of the product of sign-extended operands are the signed product.
    prod_s  = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    b_zero  = (b == '0);
    b_safe  = b_zero ? WIDTH'(1) : b;
    div_ovf = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    q_s     = $signed(a) / $signed(b_safe);
    r_s     = $signed(a) % $signed(b_safe);
    q_u     = a / b_safe;
    r_u     = a % b_safe;

    hi_n = hi;
    lo_n = lo;
    we   = 1'b0;
    case (op)
      MDU_MULT: begin
        {hi_n, lo_n} = prod_s;
        we           = 1'b1;
      end
      MDU_MULTU: begin
        {hi_n, lo_n} = prod_u;
        we           = 1'b1;
      end
      MDU_DIV: begin
        lo_n = div_ovf ? a : q_s;
        hi_n = div_ovf ? '0 : r_s;
        we   = !b_zero;
      end
      MDU_DIVU: begin
        lo_n = q_u;
        hi_n = r_u;
        we   = !b_zero;
      end
`ifdef MDU_MADD_EN
      MDU_MADD: begin
        {hi_n, lo_n} = {hi, lo} + prod_s;
        we           = 1'b1;
      end
      MDU_MADDU: begin
        {hi_n, lo_n} = {hi, lo} + prod_u;
        we           = 1'b1;
      end
      MDU_MSUB: begin
        {hi_n, lo_n} = {hi, lo} - prod_s;
        we           = 1'b1;
      end
      MDU_MSUBU: begin
        {hi_n, lo_n} = {hi, lo} - prod_u;
        we           = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO pair, MULT_CYCLES/DIV_CYCLES busy window, mt*/mf* in one cycle.
// No backpressure: start while busy is dropped (hazard unit prevents it); MDU_MADD_EN enables MADD/MSUB.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] rd_o
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] base_hi_q, base_hi_d;
  logic [WIDTH-1:0] base_lo_q, base_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic             res_we;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .hi  (base_hi_q),
    .lo  (base_lo_q),
    .hi_n(hi_n),
    .lo_n(lo_n),
    .we  (res_we)
  );

  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    base_hi_d = base_hi_q;
    base_lo_d = base_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      // HI/LO stay at their old values until the last busy edge.
      if ((cnt_q == CW'(1)) && res_we) begin
        hi_d = hi_n;
        lo_d = lo_n;
      end
    end else if (start) begin
      if (is_mul_op(op) || is_div_op(op)) begin
        cnt_d     = is_mul_op(op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        op_d      = op;
        a_d       = a;
        b_d       = b;
        base_hi_d = hi_q;
        base_lo_d = lo_q;
      end else if (op == MDU_MTHI) begin
        hi_d = a;
      end else if (op == MDU_MTLO) begin
        lo_d = a;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      op_q      <= MDU_NOP;
      a_q       <= '0;
      b_q       <= '0;
      base_hi_q <= '0;
      base_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      base_hi_q <= base_hi_d;
      base_lo_q <= base_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign hi_o = hi_q;
  assign lo_o = lo_q;
  assign rd_o = (op == MDU_MFHI) ? hi_q :
                (op == MDU_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboarded random/directed bench for e_mdu against a plain-arithmetic HI/LO model.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi_o, lo_o, rd_o;

  e_mdu #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi_o (hi_o),
    .lo_o (lo_o),
    .rd_o (rd_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi, m_lo;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: new {HI,LO} and busy length for one accepted op.
  task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] h_in, input logic [31:0] l_in,
                       output logic [31:0] h_out, output logic [31:0] l_out, output int cyc);
    longint      sx, sy, ma, mb, q, r;
    logic [63:0] p;
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    h_out = h_in;
    l_out = l_in;
    cyc   = 0;
    case (o)
      MDU_MULT:  begin p = 64'(sx * sy); {h_out, l_out} = p; cyc = MC; end
      MDU_MULTU: begin p = {32'h0, x} * {32'h0, y}; {h_out, l_out} = p; cyc = MC; end
      MDU_DIV: begin
        cyc = DC;
        if (y != 0) begin
          ma = (sx < 0) ? -sx : sx;
          mb = (sy < 0) ? -sy : sy;
          q  = ma / mb;
          r  = ma % mb;
          if ((sx < 0) != (sy < 0)) q = -q;
          if (sx < 0) r = -r;
          l_out = 32'(q);
          h_out = 32'(r);
        end
      end
      MDU_DIVU: begin
        cyc = DC;
        if (y != 0) begin
          l_out = x / y;
          h_out = x % y;
        end
      end
      MDU_MTHI: h_out = x;
      MDU_MTLO: l_out = x;
`ifdef MDU_MADD_EN
      MDU_MADD:  begin p = {h_in, l_in} + 64'(sx * sy); {h_out, l_out} = p; cyc = MC; end
      MDU_MADDU: begin p = {h_in, l_in} + {32'h0, x} * {32'h0, y}; {h_out, l_out} = p; cyc = MC; end
      MDU_MSUB:  begin p = {h_in, l_in} - 64'(sx * sy); {h_out, l_out} = p; cyc = MC; end
      MDU_MSUBU: begin p = {h_in, l_in} - {32'h0, x} * {32'h0, y}; {h_out, l_out} = p; cyc = MC; end
`endif
      default: ;
    endcase
  endtask

  // Monitor: a completed operation is the busy falling edge.
  int   run_len   = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      run_len   = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        run_len++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got completion, expected none");
        end else begin
          e = sb.pop_front();
          check("busy_len", 64'(run_len), 64'(e.cycles));
          check("done_hi", {32'h0, hi_o}, {32'h0, e.hi});
          check("done_lo", {32'h0, lo_o}, {32'h0, e.lo});
        end
        run_len = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_idle();
    int g = 0;
    while ((busy || sb.size() != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (busy || sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: got busy=%0b pending=%0d, expected idle", busy, sb.size());
    end
  endtask

  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] nh, nl, exp_rd;
    int          cyc;
    exp_t        e;
    @(negedge clk);
    wait_idle();
    model(o, x, y, m_hi, m_lo, nh, nl, cyc);
    exp_rd = (o == MDU_MFHI) ? m_hi : (o == MDU_MFLO) ? m_lo : 32'h0;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    #1;
    check("rd_o", {32'h0, rd_o}, {32'h0, exp_rd});
    if (cyc > 0) begin
      e.hi     = nh;
      e.lo     = nl;
      e.cycles = cyc;
      sb.push_back(e);
    end
    m_hi = nh;
    m_lo = nl;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = MDU_NOP;
    check("busy_after_accept", {63'h0, busy}, {63'h0, (cyc > 0)});
    if (cyc == 0) begin
      check("imm_hi", {32'h0, hi_o}, {32'h0, m_hi});
      check("imm_lo", {32'h0, lo_o}, {32'h0, m_lo});
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] sp[5];
    sp[0] = 32'h0;
    sp[1] = 32'h1;
    sp[2] = 32'hFFFF_FFFF;
    sp[3] = 32'h8000_0000;
    sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 40)) - 32'd20;
    return $urandom;
  endfunction

  initial begin
    logic [3:0] ops[13];
    ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MFHI,
            MDU_MFLO, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU, MDU_NOP};
    reset = 1'b1;
    start = 1'b0;
    op    = MDU_NOP;
    a     = '0;
    b     = '0;
    m_hi  = '0;
    m_lo  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_hi", {32'h0, hi_o}, 64'h0);
    check("rst_lo", {32'h0, lo_o}, 64'h0);
    check("rst_rd", {32'h0, rd_o}, 64'h0);
    reset = 1'b0;

    do_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle();
    check("mult_hi", {32'h0, hi_o}, 64'hFFFF_FFFF);
    check("mult_lo", {32'h0, lo_o}, 64'hFFFF_FFFA);

    do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    check("multu_hi", {32'h0, hi_o}, 64'hFFFF_FFFE);
    check("multu_lo", {32'h0, lo_o}, 64'h0000_0001);

    do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    check("div_hi", {32'h0, hi_o}, 64'hFFFF_FFFF);
    check("div_lo", {32'h0, lo_o}, 64'hFFFF_FFFD);

    do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    check("divovf_hi", {32'h0, hi_o}, 64'h0);
    check("divovf_lo", {32'h0, lo_o}, 64'h8000_0000);

    do_op(MDU_MTHI, 32'd5, 32'd0);
    do_op(MDU_MTLO, 32'd6, 32'd0);
    do_op(MDU_DIVU, 32'd1234, 32'd0);
    wait_idle();
    check("div0_hi", {32'h0, hi_o}, 64'd5);
    check("div0_lo", {32'h0, lo_o}, 64'd6);
    do_op(MDU_MFHI, 32'd0, 32'd0);
    do_op(MDU_MFLO, 32'd0, 32'd0);

    do_op(MDU_MTHI, 32'd0, 32'd0);
    do_op(MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
    do_op(MDU_MADDU, 32'd1, 32'd1);
    wait_idle();
`ifdef MDU_MADD_EN
    check("maddu_hi", {32'h0, hi_o}, 64'd1);
    check("maddu_lo", {32'h0, lo_o}, 64'd0);
`else
    check("maddu_nop_hi", {32'h0, hi_o}, 64'd0);
    check("maddu_nop_lo", {32'h0, lo_o}, 64'hFFFF_FFFF);
`endif

    // A start while busy must not disturb the in-flight multiply.
    do_op(MDU_MULT, 32'd7, 32'hFFFF_FFFD);
    @(negedge clk);
    start = 1'b1;
    op    = MDU_MTHI;
    a     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = MDU_NOP;
    wait_idle();
    check("ignored_hi", {32'h0, hi_o}, 64'hFFFF_FFFF);
    check("ignored_lo", {32'h0, lo_o}, 64'hFFFF_FFEB);

    // Reset during busy cycle 2 aborts immediately.
    do_op(MDU_MTHI, 32'h1234_5678, 32'd0);
    do_op(MDU_MULT, 32'd100, 32'd100);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_hi", {32'h0, hi_o}, 64'h0);
    check("abort_lo", {32'h0, lo_o}, 64'h0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (MC + 1) @(negedge clk);
    check("post_abort_hi", {32'h0, hi_o}, 64'h0);
    check("post_abort_busy", {63'h0, busy}, 64'h0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] x, y;
      x = rand_operand();
      y = rand_operand();
      do_op(ops[$urandom_range(0, 12)], x, y);
    end
    wait_idle();
    check("final_hi", {32'h0, hi_o}, {32'h0, m_hi});
    check("final_lo", {32'h0, lo_o}, {32'h0, m_lo});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

endmodule
